instr_ram: RTL and testbench

INSTR_RAM -- requirements
Module: instr_ram

---
 rtl/risc_pkg.sv | 25 ++
 rtl/instr_loader.sv | 81 ++++++++
 rtl/instr_ram.sv | 105 ++++++++++
 tb/tb_instr_ram.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcode constants, special instruction words and loader state encoding
package risc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  // all-ones is a reserved encoding, distinct from the reset value of the fetch register
  localparam logic [31:0] ILLOP_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - loader FSM and write pointer for streaming words into the instruction array
module instr_loader
  import risc_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start_i,
  input  logic [ADDR_W-1:0] ld_base_i,
  input  logic              ld_valid_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              ld_done_o,
  output logic              ld_err_o,
  output logic              cpu_hold_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              err_q, err_d;
  logic              accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    ld_ready_o = 1'b0;
    ld_done_o  = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        if (ld_start_i) begin
          state_d = LD_LOAD;
          ptr_d   = ld_base_i;
          err_d   = 1'b0;
        end
      end
      LD_LOAD: begin
        ld_ready_o = 1'b1;
        if (ld_valid_i) begin
          accept = 1'b1;
          // the pointer parks at the top word instead of wrapping
          if (!(&ptr_q)) ptr_d = ptr_q + 1'b1;
          if (ld_last_i) begin
            state_d = LD_DONE;
          end else if (&ptr_q) begin
            state_d = LD_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      LD_DONE: begin
        ld_done_o = 1'b1;
        state_d   = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // a word presented on the reset edge must not land in the array
  assign wr_en_o    = accept & rst_n;
  assign wr_addr_o  = ptr_q;
  assign ld_err_o   = err_q;
  assign cpu_hold_o = (state_q != LD_IDLE);

endmodule

// File: rtl/instr_ram.sv
// rtl/instr_ram.sv - instruction array with registered fetch, stream loader and program base table
module instr_ram
  import risc_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int NUM_PROGS = 8,
  localparam int PSEL_W   = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc,
  output logic [DATA_W-1:0] id,
  output logic              id_valid,
  output logic              illop,
  output logic              cpu_hold,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  input  logic              tbl_we,
  input  logic [PSEL_W-1:0] tbl_idx,
  input  logic [31:0]       tbl_addr,
  input  logic [PSEL_W-1:0] prog_sel,
  output logic [31:0]       prog_base
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned TBL_N = 1 << PSEL_W;

  if (ADDR_W > 30) begin : g_addr_w_check
    $error("instr_ram: ADDR_W must not exceed 30");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] id_q;
  logic              id_valid_q;
  logic              illop_q;
  logic [31:0]       tbl_q [TBL_N];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              legal;

  instr_loader #(
    .ADDR_W(ADDR_W)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_start_i (ld_start),
    .ld_base_i  (ld_base),
    .ld_valid_i (ld_valid),
    .ld_last_i  (ld_last),
    .ld_ready_o (ld_ready),
    .ld_done_o  (ld_done),
    .ld_err_o   (ld_err),
    .cpu_hold_o (cpu_hold),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr)
  );

  assign rd_addr = pc[ADDR_W+1:2];
  assign legal   = (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < 32'(DEPTH));

  // array is deliberately left out of reset so loaded programs survive it
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q       <= '0;
      id_valid_q <= 1'b0;
      illop_q    <= 1'b0;
    end else if (cpu_hold) begin
      id_valid_q <= 1'b0;
      illop_q    <= 1'b0;
    end else begin
      id_valid_q <= 1'b1;
      illop_q    <= !legal;
      id_q       <= legal ? mem_q[rd_addr] : DATA_W'(ILLOP_INSTR);
    end
  end

  // entries past NUM_PROGS exist only to keep indexing power-of-two; they stay zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TBL_N); i++) tbl_q[i] <= '0;
    end else if (tbl_we && (32'(tbl_idx) < 32'(NUM_PROGS))) begin
      tbl_q[tbl_idx] <= tbl_addr;
    end
  end

  assign prog_base = (32'(prog_sel) < 32'(NUM_PROGS)) ? tbl_q[prog_sel] : 32'h0;

  assign id       = id_q;
  assign id_valid = id_valid_q;
  assign illop    = illop_q;

endmodule

// File: tb/tb_instr_ram.sv
// tb/tb_instr_ram.sv - self-checking bench for instr_ram: fetch vectors, loader corners, table port
module tb_instr_ram;
  import risc_pkg::*;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 32;
  localparam int NUM_PROGS = 6;
  localparam int PSEL_W    = 3;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       pc;
  logic [DATA_W-1:0] id;
  logic              id_valid, illop, cpu_hold;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready, ld_done, ld_err;
  logic              tbl_we;
  logic [PSEL_W-1:0] tbl_idx;
  logic [31:0]       tbl_addr;
  logic [PSEL_W-1:0] prog_sel;
  logic [31:0]       prog_base;

  always #5 clk = ~clk;

  instr_ram #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_PROGS(NUM_PROGS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc       (pc),
    .id       (id),
    .id_valid (id_valid),
    .illop    (illop),
    .cpu_hold (cpu_hold),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_err   (ld_err),
    .tbl_we   (tbl_we),
    .tbl_idx  (tbl_idx),
    .tbl_addr (tbl_addr),
    .prog_sel (prog_sel),
    .prog_base(prog_base)
  );

  typedef struct {
    logic [31:0] data;
    logic        ill;
  } fexp_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] exp_id;
    logic        exp_ill;
  } vec_t;

  localparam logic [31:0] W_Z = 32'h0000_0513;
  localparam logic [31:0] W_A = 32'hA000_00A1;
  localparam logic [31:0] W_B = 32'hB000_00B2;
  localparam logic [31:0] W_C = 32'hC000_00C3;

  int    n_cmp = 0;
  int    n_bad = 0;
  fexp_t sb_q[$];
  vec_t  vecs[9];
  logic [31:0] held;
  logic [31:0] w_abc [3];
  logic [31:0] w_ovf [3];
  logic [31:0] w_tog [4];
  logic [31:0] w_rst [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] exp_id, input logic exp_ill);
    fexp_t e;
    pc = a;
    e.data = exp_id;
    e.ill  = exp_ill;
    sb_q.push_back(e);
    step();
    e = sb_q.pop_front();
    chk({name, " id"}, id, e.data);
    chk({name, " id_valid"}, 32'(id_valid), 32'd1);
    chk({name, " illop"}, 32'(illop), 32'(e.ill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w_abc = '{W_A, W_B, W_C};
    w_ovf = '{32'h0F0F_0001, 32'h0F0F_0002, 32'h0F0F_0003};
    w_tog = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
    w_rst = '{32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003};
    vecs[0] = '{"pc16",      32'd16,         W_A,         1'b0};
    vecs[1] = '{"pc20",      32'd20,         W_B,         1'b0};
    vecs[2] = '{"pc24",      32'd24,         W_C,         1'b0};
    vecs[3] = '{"pc0",       32'd0,          W_Z,         1'b0};
    vecs[4] = '{"pc202",     32'h202,        ILLOP_INSTR, 1'b1};
    vecs[5] = '{"pc4xdepth", 32'(4 * DEPTH), ILLOP_INSTR, 1'b1};
    vecs[6] = '{"pc_high",   32'h8000_0010,  ILLOP_INSTR, 1'b1};
    vecs[7] = '{"pc_mis1",   32'h11,         ILLOP_INSTR, 1'b1};
    vecs[8] = '{"pc20_again",32'd20,         W_B,         1'b0};

    rst_n = 1'b0; pc = 32'h3; ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0;
    ld_data = '0; ld_last = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; prog_sel = 3'd2;
    step(); step();
    chk("rst id", id, 32'h0);
    chk("rst id_valid", 32'(id_valid), 32'd0);
    chk("rst illop", 32'(illop), 32'd0);
    chk("rst ld_ready", 32'(ld_ready), 32'd0);
    chk("rst ld_done", 32'(ld_done), 32'd0);
    chk("rst ld_err", 32'(ld_err), 32'd0);
    chk("rst cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst prog_base", prog_base, 32'h0);

    // single-word load at word 0; the start edge still fetches misaligned pc 3
    rst_n = 1'b1; ld_start = 1'b1; ld_base = '0;
    step();
    ld_start = 1'b0; held = ILLOP_INSTR;
    chk("z start cpu_hold", 32'(cpu_hold), 32'd1);
    chk("z start ld_ready", 32'(ld_ready), 32'd1);
    chk("z start illop", 32'(illop), 32'd1);
    ld_valid = 1'b1; ld_data = W_Z; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("z ld_done", 32'(ld_done), 32'd1);
    chk("z done ld_ready", 32'(ld_ready), 32'd0);
    chk("z hold id", id, held);
    chk("z hold id_valid", 32'(id_valid), 32'd0);
    chk("z hold illop", 32'(illop), 32'd0);
    step();
    chk("z ld_done gone", 32'(ld_done), 32'd0);
    chk("z cpu_hold gone", 32'(cpu_hold), 32'd0);

    // A,B,C at word 4
    ld_start = 1'b1; ld_base = 7'd4;
    step();
    ld_start = 1'b0;
    chk("abc cpu_hold", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = w_abc[i]; ld_last = (i == 2);
      step();
      chk($sformatf("abc beat%0d ld_done", i), 32'(ld_done), 32'(i == 2));
      chk($sformatf("abc beat%0d id held", i), id, held);
      chk($sformatf("abc beat%0d id_valid", i), 32'(id_valid), 32'd0);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    ld_start = 1'b1; ld_base = 7'd9;
    step();
    ld_start = 1'b0;
    chk("abc ld_done pulse", 32'(ld_done), 32'd0);
    chk("abc start in DONE ignored", 32'(cpu_hold), 32'd0);
    chk("abc ld_ready idle", 32'(ld_ready), 32'd0);

    for (int i = 0; i < 9; i++) fetch(vecs[i].name, vecs[i].pc, vecs[i].exp_id, vecs[i].exp_ill);

    // overflow at the top of the array
    pc = 32'd16; ld_start = 1'b1; ld_base = 7'(DEPTH - 2);
    step();
    ld_start = 1'b0; held = W_A;
    ld_valid = 1'b1; ld_data = w_ovf[0];
    step();
    chk("ovf beat0 ld_err", 32'(ld_err), 32'd0);
    chk("ovf beat0 ld_ready", 32'(ld_ready), 32'd1);
    chk("ovf beat0 id held", id, held);
    ld_data = w_ovf[1];
    step();
    chk("ovf beat1 ld_err", 32'(ld_err), 32'd1);
    chk("ovf beat1 ld_ready", 32'(ld_ready), 32'd0);
    chk("ovf beat1 cpu_hold", 32'(cpu_hold), 32'd0);
    chk("ovf beat1 ld_done", 32'(ld_done), 32'd0);
    ld_data = w_ovf[2];
    step();
    ld_valid = 1'b0;
    chk("ovf beat2 ld_err sticky", 32'(ld_err), 32'd1);
    chk("ovf beat2 ld_done", 32'(ld_done), 32'd0);
    fetch("ovf word126", 32'(4 * (DEPTH - 2)), w_ovf[0], 1'b0);
    fetch("ovf word127", 32'(4 * (DEPTH - 1)), w_ovf[1], 1'b0);
    fetch("ovf no wrap", 32'd0, W_Z, 1'b0);

    // gappy stream with ld_start re-pulsed mid-load
    pc = 32'd24; ld_start = 1'b1; ld_base = 7'd40;
    step();
    ld_start = 1'b0; held = W_C;
    chk("tog ld_err cleared", 32'(ld_err), 32'd0);
    begin
      int k;
      int c;
      k = 0;
      c = 0;
      while (k < 4 && c < 20) begin
        ld_valid = ((c % 2) == 1);
        ld_start = (c == 2 || c == 5);
        ld_base  = 7'd90;
        ld_data  = 32'hBAD0_0000 + 32'(c);
        ld_last  = 1'b0;
        if (ld_valid) begin
          ld_data = w_tog[k];
          ld_last = (k == 3);
        end
        step();
        if (ld_valid) k++;
        chk($sformatf("tog c%0d cpu_hold", c), 32'(cpu_hold), 32'd1);
        chk($sformatf("tog c%0d id held", c), id, held);
        c++;
      end
      chk("tog beats accepted", 32'(k), 32'd4);
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
    chk("tog ld_done", 32'(ld_done), 32'd1);
    step();
    chk("tog ld_done gone", 32'(ld_done), 32'd0);
    chk("tog cpu_hold gone", 32'(cpu_hold), 32'd0);
    for (int i = 0; i < 4; i++) fetch($sformatf("tog word%0d", 40 + i), 32'(4 * (40 + i)), w_tog[i], 1'b0);

    // program table
    tbl_we = 1'b1; tbl_idx = 3'd2; tbl_addr = 32'hDC; prog_sel = 3'd2;
    #1;
    chk("tbl same-cycle old value", prog_base, 32'h0);
    step();
    tbl_we = 1'b0;
    chk("tbl idx2 next cycle", prog_base, 32'hDC);
    tbl_we = 1'b1; tbl_idx = 3'd5; tbl_addr = 32'h400; prog_sel = 3'd5;
    step();
    tbl_we = 1'b0;
    chk("tbl idx5", prog_base, 32'h400);
    tbl_we = 1'b1; tbl_idx = 3'd6; tbl_addr = 32'h777; prog_sel = 3'd6;
    step();
    tbl_we = 1'b0;
    chk("tbl idx6 out of range", prog_base, 32'h0);
    prog_sel = 3'd2;
    #1;
    chk("tbl idx2 retained", prog_base, 32'hDC);

    // reset after two of four beats
    pc = 32'd16; ld_start = 1'b1; ld_base = 7'd64;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = w_rst[0];
    step();
    ld_data = w_rst[1];
    step();
    ld_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mid-rst cpu_hold", 32'(cpu_hold), 32'd0);
    chk("mid-rst ld_ready", 32'(ld_ready), 32'd0);
    chk("mid-rst ld_done", 32'(ld_done), 32'd0);
    chk("mid-rst ld_err", 32'(ld_err), 32'd0);
    chk("mid-rst id", id, 32'h0);
    chk("mid-rst id_valid", 32'(id_valid), 32'd0);
    chk("mid-rst table cleared", prog_base, 32'h0);
    rst_n = 1'b1;
    step();
    chk("post-rst ld_done", 32'(ld_done), 32'd0);
    chk("post-rst cpu_hold", 32'(cpu_hold), 32'd0);
    fetch("rst word64", 32'd256, w_rst[0], 1'b0);
    fetch("rst word65", 32'd260, w_rst[1], 1'b0);
    fetch("rst array persists", 32'd16, W_A, 1'b0);

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
